sigmoid_tanh_approx_q15: RTL and testbench
==========================================

# sigmoid_tanh_approx_q15

Registered Q1.15 activation unit producing piecewise-linear tanh and sigmoid of one signed input sample per cycle. It serves as the nonlinearity stage of the discriminator datapath: tanh after the hidden FC layer, sigmoid after the output FC layer. Both results are bit-exact, table-driven and symmetric about zero.

## Interface
- SIGMOID_EN, default 1: 1 computes sigmoid_y; 0 ties sigmoid_y to 0 and removes the second core.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  x is sampled this cycle.
- x  in  16 signed  Q1.15 input, range [-1, 1).
- out_valid  out  1  tanh_y and sigmoid_y are valid.
- tanh_y  out  16 signed  Q1.15 approximation of tanh(x).
- sigmoid_y  out  16 signed  Q1.15 approximation of sigmoid(x), always positive.

## Operation
- Node table T[k] = round(tanh(k/8)·32768), k = 0..8: 0, 4075, 8026, 11743, 15143, 18173, 20813, 23066, 24956.
- tanh core, input v (16-bit signed):
  - m = |v| as a 17-bit unsigned value, so v = -32768 gives m = 32768.
  - k = m[15:12], r = m[11:0].
  - If k = 8, then mag = T[8]. Otherwise mag = T[k] + floor(((T[k+1] − T[k]) · r) / 4096), with an unsigned 24-bit product.
  - Result = mag if v ≥ 0, else −mag.
- tanh_y = core(x).
- sigmoid_y = 16384 + (core(x >>> 1) >>> 1). Both shifts are arithmetic, i.e. floor.
- No saturation logic is needed: |tanh_y| ≤ 24956 and sigmoid_y lies in [8812, 23955].
- Odd symmetry is exact: core(−v) = −core(v) for v ≠ −32768.
- Accuracy versus the real functions is ≤ 64 LSB over the full input range.

## Timing
- Latency is 1 cycle. A sample taken with in_valid high at edge n appears on the outputs after edge n, with out_valid = 1.
- When in_valid is low at an edge, out_valid goes 0 and tanh_y and sigmoid_y hold their previous values.
- Back-to-back samples are accepted every cycle. There is no backpressure.
- Reset:
  - Asserting rst immediately clears out_valid, tanh_y and sigmoid_y to 0, with no clock required.
  - A sample in flight is discarded.
  - The first sample is accepted at the first edge after rst deasserts.
- All arithmetic between x and the output registers is combinational in the same cycle.

## Structure
- Shared package act_q15_pkg holds:
  - the Q1.15 width constant (16);
  - the segment constants (SEG_BITS = 3, FRAC_BITS = 12);
  - the 9-entry T table as localparam constants;
  - the Q15 half constant (16384).
- One sub-module, tanh_pwl_core: purely combinational, 16-bit signed in and out, implementing the core above.
  - Instance 1 is the tanh path.
  - Instance 2 is the sigmoid path, generated only when SIGMOID_EN = 1.
- The top level contains the input shift, the sigmoid offset/shift and the output registers.

## Test plan
- x = 0x0000 → tanh_y = 0, sigmoid_y = 16384. x = 0x4000 (0.5) → tanh_y = 15143, sigmoid_y = 20397.
- x = 0xC000 (−0.5) → tanh_y = −15143, sigmoid_y = 12371. x = 0x8000 → tanh_y = −24956, sigmoid_y = 8812.
- x = 0x7FFF → tanh_y = 24955, sigmoid_y = 23955.
- Exhaustive sweep of all 65536 inputs:
  - compare against a bit-exact model;
  - check |error| ≤ 64 LSB versus real tanh and sigmoid;
  - check tanh_y(−x) = −tanh_y(x);
  - check sigmoid_y is monotonic non-decreasing.
- in_valid pattern 1,1,0,1 with x = 0x4000, 0xC000, 0x1234, 0x0000:
  - out_valid is 1,1,0,1, one cycle later;
  - values are 15143, −15143, held −15143, then 0.
- Assert rst mid-stream between clock edges → all outputs are 0 immediately. Release rst, apply x = 0x4000 → tanh_y = 15143 one cycle later.

Source files
------------

// File: rtl/act_q15_pkg.sv
// Shared Q1.15 constants and the tanh node table for the piecewise-linear activation cores.
package act_q15_pkg;

    localparam int Q15_WIDTH = 16;
    localparam int SEG_BITS  = 3;
    localparam int FRAC_BITS = 12;
    localparam int SEG_COUNT = 1 << SEG_BITS;

    localparam logic signed [Q15_WIDTH-1:0] Q15_HALF = 16'sd16384;

    // Node table: round(tanh(k/8) * 32768), k = 0..8.
    localparam logic [Q15_WIDTH-1:0] T0 = 16'd0;
    localparam logic [Q15_WIDTH-1:0] T1 = 16'd4075;
    localparam logic [Q15_WIDTH-1:0] T2 = 16'd8026;
    localparam logic [Q15_WIDTH-1:0] T3 = 16'd11743;
    localparam logic [Q15_WIDTH-1:0] T4 = 16'd15143;
    localparam logic [Q15_WIDTH-1:0] T5 = 16'd18173;
    localparam logic [Q15_WIDTH-1:0] T6 = 16'd20813;
    localparam logic [Q15_WIDTH-1:0] T7 = 16'd23066;
    localparam logic [Q15_WIDTH-1:0] T8 = 16'd24956;

    function automatic logic [Q15_WIDTH-1:0] t_node(input logic [SEG_BITS:0] k);
        case (k)
            4'd0:    return T0;
            4'd1:    return T1;
            4'd2:    return T2;
            4'd3:    return T3;
            4'd4:    return T4;
            4'd5:    return T5;
            4'd6:    return T6;
            4'd7:    return T7;
            4'd8:    return T8;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/sigmoid_tanh_approx_q15_if.sv
// Sample/result bundle between the datapath and the activation unit.
interface sigmoid_tanh_approx_q15_if;
    import act_q15_pkg::*;

    logic                        in_valid;
    logic signed [Q15_WIDTH-1:0] x;
    logic                        out_valid;
    logic signed [Q15_WIDTH-1:0] tanh_y;
    logic signed [Q15_WIDTH-1:0] sigmoid_y;

    modport master (output in_valid, x, input out_valid, tanh_y, sigmoid_y);
    modport slave  (input in_valid, x, output out_valid, tanh_y, sigmoid_y);

endinterface

// File: rtl/tanh_pwl_core.sv
// Combinational piecewise-linear tanh over 8 segments of width 1/8, odd-symmetric about zero.
module tanh_pwl_core
    import act_q15_pkg::*;
(
    input  logic signed [Q15_WIDTH-1:0] v,
    output logic signed [Q15_WIDTH-1:0] y
);

    logic [Q15_WIDTH-1:0]   m;
    logic [SEG_BITS:0]      k;
    logic [SEG_BITS:0]      k_next;
    logic [FRAC_BITS-1:0]   r;
    logic [Q15_WIDTH-1:0]   base;
    logic [Q15_WIDTH-1:0]   nxt;
    logic [FRAC_BITS-1:0]   diff;
    logic [2*FRAC_BITS-1:0] prod;
    logic [Q15_WIDTH-1:0]   mag;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        // Unsigned 16 bits is enough: |-32768| = 0x8000 still reads as 32768.
        m      = v[Q15_WIDTH-1] ? Q15_WIDTH'(-v) : Q15_WIDTH'(v);
        k      = m[FRAC_BITS+SEG_BITS:FRAC_BITS];
        r      = m[FRAC_BITS-1:0];
        k_next = k + 1'b1;
        base   = t_node(k);
        nxt    = t_node(k_next);
        // Adjacent nodes differ by at most 4075, so the slope fits the fraction width.
        diff   = FRAC_BITS'(nxt - base);
        prod   = {{FRAC_BITS{1'b0}}, diff} * {{FRAC_BITS{1'b0}}, r};
        if (k == (SEG_BITS+1)'(SEG_COUNT))
            mag = base;
        else
            mag = base + Q15_WIDTH'(prod >> FRAC_BITS);
        y = v[Q15_WIDTH-1] ? $signed(-mag) : $signed(mag);
    end

endmodule

// File: rtl/sigmoid_tanh_approx_q15.sv
// Registered Q1.15 tanh and sigmoid; sigmoid(x) = 0.5 + tanh(x/2)/2 reuses the tanh core.
module sigmoid_tanh_approx_q15
    import act_q15_pkg::*;
#(
    parameter bit SIGMOID_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    sigmoid_tanh_approx_q15_if.slave bus
);

    logic signed [Q15_WIDTH-1:0] tanh_c;
    logic signed [Q15_WIDTH-1:0] sig_c;
    logic                        out_valid_q;
    logic signed [Q15_WIDTH-1:0] tanh_q;
    logic signed [Q15_WIDTH-1:0] sig_q;

    tanh_pwl_core u_tanh (
        .v (bus.x),
        .y (tanh_c)
    );

    generate
        if (SIGMOID_EN) begin : g_sig
            logic signed [Q15_WIDTH-1:0] sig_in;
            logic signed [Q15_WIDTH-1:0] sig_core;

            assign sig_in = $signed(bus.x) >>> 1;

            tanh_pwl_core u_sig (
                .v (sig_in),
                .y (sig_core)
            );

            assign sig_c = Q15_HALF + (sig_core >>> 1);
        end else begin : g_no_sig
            assign sig_c = '0;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            tanh_q      <= '0;
            sig_q       <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                tanh_q <= tanh_c;
                sig_q  <= sig_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.tanh_y    = tanh_q;
    assign bus.sigmoid_y = sig_q;

endmodule

// File: tb/tb_sigmoid_tanh_approx_q15.sv
// Self-checking bench: spot vectors, exhaustive sweep, valid/hold and reset sequences, random traffic.
module tb_sigmoid_tanh_approx_q15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sigmoid_tanh_approx_q15_if bus ();

    sigmoid_tanh_approx_q15 #(.SIGMOID_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int tnode [0:8];
    int tanh_res [0:65535];
    int sig_res  [0:65535];

    typedef struct {
        logic [15:0] x;
        int          t_exp;
        int          s_exp;
    } vec_t;

    vec_t vecs [0:4];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic check_cond(input string name, input bit ok, input int act, input int ref_val);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, reference %0d", name, act, ref_val);
    endtask

    // Reference model: the segment rules evaluated on plain integers.
    function automatic int tanh_ref(input int v);
        int m, k, r, mag;
        m = (v < 0) ? -v : v;
        k = m / 4096;
        r = m % 4096;
        if (k == 8) mag = tnode[8];
        else        mag = tnode[k] + ((tnode[k+1] - tnode[k]) * r) / 4096;
        return (v < 0) ? -mag : mag;
    endfunction

    function automatic int floor_half(input int a);
        return (a < 0 && (a % 2) != 0) ? (a - 1) / 2 : a / 2;
    endfunction

    function automatic int sig_ref(input int v);
        return 16384 + floor_half(tanh_ref(floor_half(v)));
    endfunction

    task automatic step(input bit v, input logic [15:0] xv);
        bus.in_valid = v;
        bus.x        = xv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs, at, as, idx, prev, hold_t, hold_s;
        bit v;
        logic [15:0] xr;
        real rt, rs, e;

        tnode = '{0, 4075, 8026, 11743, 15143, 18173, 20813, 23066, 24956};
        vecs[0] = '{16'h0000, 0, 16384};
        vecs[1] = '{16'h4000, 15143, 20397};
        vecs[2] = '{16'hC000, -15143, 12371};
        vecs[3] = '{16'h8000, -24956, 8812};
        vecs[4] = '{16'h7FFF, 24955, 23955};

        bus.in_valid = 1'b0;
        bus.x        = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_tanh", int'(bus.tanh_y), 0);
        check("rst_sig", int'(bus.sigmoid_y), 0);
        rst = 1'b0;

        // Spot vectors
        for (int i = 0; i < 5; i++) begin
            step(1'b1, vecs[i].x);
            check("vec_valid", int'(bus.out_valid), 1);
            check("vec_tanh", int'(bus.tanh_y), vecs[i].t_exp);
            check("vec_sig", int'(bus.sigmoid_y), vecs[i].s_exp);
        end

        // Exhaustive back-to-back sweep
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 16'(i));
            xs = int'($signed(16'(i)));
            at = int'(bus.tanh_y);
            as = int'(bus.sigmoid_y);
            tanh_res[i] = at;
            sig_res[i]  = as;
            check("sweep_valid", int'(bus.out_valid), 1);
            check("sweep_tanh", at, tanh_ref(xs));
            check("sweep_sig", as, sig_ref(xs));
            rt = $tanh(real'(xs) / 32768.0) * 32768.0;
            rs = 32768.0 / (1.0 + $exp(-real'(xs) / 32768.0));
            e  = real'(at) - rt;
            if (e < 0.0) e = -e;
            check_cond("tanh_err", e <= 64.0, at, $rtoi(rt));
            e  = real'(as) - rs;
            if (e < 0.0) e = -e;
            check_cond("sig_err", e <= 64.0, as, $rtoi(rs));
        end

        for (int i = 1; i < 32768; i++)
            check("tanh_odd", tanh_res[65536 - i], -tanh_res[i]);

        for (int i = -32767; i < 32768; i++) begin
            idx  = i & 16'hFFFF;
            prev = (i - 1) & 16'hFFFF;
            check_cond("sig_mono", sig_res[idx] >= sig_res[prev], sig_res[idx], sig_res[prev]);
        end

        // Valid pattern 1,1,0,1 with hold on the gap
        step(1'b1, 16'h4000);
        check("pat0_valid", int'(bus.out_valid), 1);
        check("pat0_tanh", int'(bus.tanh_y), 15143);
        step(1'b1, 16'hC000);
        check("pat1_valid", int'(bus.out_valid), 1);
        check("pat1_tanh", int'(bus.tanh_y), -15143);
        step(1'b0, 16'h1234);
        check("pat2_valid", int'(bus.out_valid), 0);
        check("pat2_tanh_hold", int'(bus.tanh_y), -15143);
        check("pat2_sig_hold", int'(bus.sigmoid_y), 12371);
        step(1'b1, 16'h0000);
        check("pat3_valid", int'(bus.out_valid), 1);
        check("pat3_tanh", int'(bus.tanh_y), 0);

        // Random traffic with gaps against the model
        hold_t = int'(bus.tanh_y);
        hold_s = int'(bus.sigmoid_y);
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            xr = 16'($urandom);
            step(v, xr);
            if (v) begin
                hold_t = tanh_ref(int'($signed(xr)));
                hold_s = sig_ref(int'($signed(xr)));
            end
            check("rand_valid", int'(bus.out_valid), int'(v));
            check("rand_tanh", int'(bus.tanh_y), hold_t);
            check("rand_sig", int'(bus.sigmoid_y), hold_s);
        end

        // Asynchronous reset between edges, then first sample after release
        step(1'b1, 16'h7FFF);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", int'(bus.out_valid), 0);
        check("arst_tanh", int'(bus.tanh_y), 0);
        check("arst_sig", int'(bus.sigmoid_y), 0);
        #1;
        rst = 1'b0;
        step(1'b1, 16'h4000);
        check("post_rst_valid", int'(bus.out_valid), 1);
        check("post_rst_tanh", int'(bus.tanh_y), 15143);
        check("post_rst_sig", int'(bus.sigmoid_y), 20397);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
